// File: rtl/bcd_seq_calc.sv
// bcd_seq_calc: multi-cycle BCD add/sub/mul/div/mod on blank-padded operands,
// valid/ready on both sides, result in display (leading 4'hF) format.
module bcd_seq_calc #(
  parameter int unsigned DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          op,
  input  logic [4*DIGITS-1:0] a_bcd,
  input  logic [4*DIGITS-1:0] b_bcd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] result_bcd,
  output logic                neg,
  output logic                ovf,
  output logic                div0,
  output logic                bad
);
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned PW = 2 * BW;
  localparam int unsigned CW = $clog2(BW + 1);

  localparam logic [3:0] OP_ADD = 4'hD;
  localparam logic [3:0] OP_SUB = 4'hC;
  localparam logic [3:0] OP_MUL = 4'hB;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_MOD = 4'h9;

  localparam logic [BW-1:0] BLANK_ZERO = {{(DIGITS-1){4'hF}}, 4'h0};

  function automatic logic [PW-1:0] max_value();
    logic [PW-1:0] v;
    v = PW'(1);
    for (int i = 0; i < int'(DIGITS); i++) v = v * PW'(10);
    return v - PW'(1);
  endfunction

  localparam logic [PW-1:0] MAX_VAL = max_value();

  // {bad, value}: blank reads as zero, A-E flagged
  function automatic logic [4:0] nib_dec(input logic [3:0] n);
    if (n == 4'hF)      return 5'd0;
    else if (n > 4'd9)  return 5'b10000;
    else                return {1'b0, n};
  endfunction

  function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    r = d;
    for (int i = 0; i < int'(DIGITS); i++)
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Leading zero digits above digit 0 become blank
  function automatic logic [BW-1:0] blank_lead(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    logic          lead;
    r    = d;
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && d[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CHK, CONV, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [BW-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [PW-1:0] acc_a_q, acc_a_d;
  logic [BW-1:0] acc_b_q, acc_b_d;
  logic [PW-1:0] res_q, res_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic          out_valid_q, out_valid_d;
  logic [BW-1:0] result_q, result_d;
  logic          neg_q, neg_d, ovf_q, ovf_d, div0_q, div0_d, bad_q, bad_d;

  logic [4:0]    dig_a, dig_b;
  logic [BW:0]   rem_sh, rem_sub;
  logic [PW-1:0] sel;
  logic [BW-1:0] bcd_adj;
  logic          op_ok, is_divmod, qbit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    res_d       = res_q;
    bcd_d       = bcd_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    div0_d      = div0_q;
    bad_d       = bad_q;
    qbit        = 1'b0;
    dig_a       = nib_dec(a_sh_q[BW-1 -: 4]);
    dig_b       = nib_dec(b_sh_q[BW-1 -: 4]);
    rem_sh      = {res_q[BW-1:0], acc_a_q[BW-1]};
    rem_sub     = rem_sh - {1'b0, acc_b_q};
    sel         = (op_q == OP_DIV) ? PW'(acc_a_q[BW-1:0]) : res_q;
    bcd_adj     = dd_adjust(bcd_q);
    op_ok       = (op_q >= OP_MOD) && (op_q <= OP_ADD);
    is_divmod   = (op_q == OP_DIV) || (op_q == OP_MOD);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d     = op;
          a_sh_d   = a_bcd;
          b_sh_d   = b_bcd;
          acc_a_d  = '0;
          acc_b_d  = '0;
          res_d    = '0;
          cnt_d    = '0;
          neg_d    = 1'b0;
          ovf_d    = 1'b0;
          div0_d   = 1'b0;
          bad_d    = 1'b0;
          result_d = BLANK_ZERO;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        acc_a_d = acc_a_q * PW'(10) + PW'(dig_a[3:0]);
        acc_b_d = acc_b_q * BW'(10) + BW'(dig_b[3:0]);
        a_sh_d  = a_sh_q << 4;
        b_sh_d  = b_sh_q << 4;
        bad_d   = bad_q | dig_a[4] | dig_b[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) begin
          cnt_d = '0;
          if (bad_d || !op_ok) begin
            bad_d   = 1'b1;
            state_d = CHK;
          end else if (is_divmod && acc_b_d == '0) begin
            div0_d  = 1'b1;
            state_d = CHK;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (op_q == OP_ADD) begin
          res_d   = acc_a_q + PW'(acc_b_q);
          state_d = CHK;
        end else if (op_q == OP_SUB) begin
          if (acc_a_q >= PW'(acc_b_q)) begin
            res_d = acc_a_q - PW'(acc_b_q);
          end else begin
            res_d = PW'(acc_b_q) - acc_a_q;
            neg_d = 1'b1;
          end
          state_d = CHK;
        end else begin
          if (op_q == OP_MUL) begin
            if (acc_b_q[0]) res_d = res_q + acc_a_q;
            acc_a_d = acc_a_q << 1;
            acc_b_d = acc_b_q >> 1;
          end else begin
            // restoring division: remainder in res_q, quotient shifts into acc_a_q
            if (rem_sh >= {1'b0, acc_b_q}) begin
              res_d = PW'(rem_sub);
              qbit  = 1'b1;
            end else begin
              res_d = PW'(rem_sh);
            end
            acc_a_d = PW'({acc_a_q[BW-2:0], qbit});
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BW - 1)) begin
            cnt_d   = '0;
            state_d = CHK;
          end
        end
      end
      CHK: begin
        if (bad_q || div0_q) begin
          state_d = DONE;
        end else if (sel > MAX_VAL) begin
          ovf_d   = 1'b1;
          state_d = DONE;
        end else begin
          res_d   = sel;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {bcd_adj[BW-2:0], res_q[BW-1]};
        res_d = res_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BW - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          result_d    = (bad_q || div0_q || ovf_q) ? BLANK_ZERO : blank_lead(bcd_q);
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      res_q       <= '0;
      bcd_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= BLANK_ZERO;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      res_q       <= res_d;
      bcd_q       <= bcd_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      div0_q      <= div0_d;
      bad_q       <= bad_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign result_bcd = result_q;
  assign neg        = neg_q;
  assign ovf        = ovf_q;
  assign div0       = div0_q;
  assign bad        = bad_q;

endmodule

// File: tb/tb_bcd_seq_calc.sv
// Directed + small random bench for bcd_seq_calc (DIGITS=6) with an
// integer reference model and an expected-result queue.
module tb_bcd_seq_calc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'h0;
  logic [23:0] a_bcd = '1;
  logic [23:0] b_bcd = '1;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] result_bcd;
  logic        neg, ovf, div0, bad;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [23:0] res;
    logic        neg;
    logic        ovf;
    logic        div0;
    logic        bad;
    int          lat;
  } exp_t;

  exp_t sb[$];

  bcd_seq_calc #(.DIGITS(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a_bcd(a_bcd), .b_bcd(b_bcd), .out_valid(out_valid), .out_ready(out_ready),
    .result_bcd(result_bcd), .neg(neg), .ovf(ovf), .div0(div0), .bad(bad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_disp(input longint v);
    logic [23:0] r;
    longint      t;
    logic        lead;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    lead = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [23:0] a, input logic [23:0] b);
    exp_t        e;
    longint      va, vb, r;
    logic [3:0]  na, nb;
    logic        isbad;
    int          ex;
    va = 0; vb = 0; isbad = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      if (na == 4'hF) na = 4'h0; else if (na > 4'd9) begin isbad = 1'b1; na = 4'h0; end
      if (nb == 4'hF) nb = 4'h0; else if (nb > 4'd9) begin isbad = 1'b1; nb = 4'h0; end
      va = va * 10 + longint'(na);
      vb = vb * 10 + longint'(nb);
    end
    e.res = 24'hFFFFF0; e.neg = 1'b0; e.ovf = 1'b0; e.div0 = 1'b0; e.bad = 1'b0; e.lat = 8;
    if (o < 4'h9 || o > 4'hD) isbad = 1'b1;
    if (isbad) begin
      e.bad = 1'b1;
    end else if ((o == 4'hA || o == 4'h9) && vb == 0) begin
      e.div0 = 1'b1;
    end else begin
      ex = (o == 4'hD || o == 4'hC) ? 1 : 24;
      case (o)
        4'hD:    r = va + vb;
        4'hC:    r = (va >= vb) ? va - vb : vb - va;
        4'hB:    r = va * vb;
        4'hA:    r = va / vb;
        default: r = va % vb;
      endcase
      if (r > 999999) begin
        e.ovf = 1'b1;
        e.lat = 6 + ex + 2;
      end else begin
        e.res = to_disp(r);
        e.neg = (o == 4'hC) && (va < vb);
        e.lat = 6 + ex + 24 + 2;
      end
    end
    return e;
  endfunction

  function automatic logic [23:0] rnd_bcd();
    logic [23:0] v;
    int          k;
    v = '1;
    k = int'($urandom_range(1, 6));
    for (int i = 0; i < k; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      if (lat == 1) chk("in_ready_busy", 64'(in_ready), 0);
    end while (!out_valid && lat < 200);
  endtask

  task automatic check_out(input string tag, input int lat);
    exp_t e;
    chk({tag, "_valid"}, 64'(out_valid), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"},  64'(lat), 64'(e.lat));
      chk({tag, "_res"},  64'(result_bcd), 64'(e.res));
      chk({tag, "_neg"},  64'(neg), 64'(e.neg));
      chk({tag, "_ovf"},  64'(ovf), 64'(e.ovf));
      chk({tag, "_div0"}, 64'(div0), 64'(e.div0));
      chk({tag, "_bad"},  64'(bad), 64'(e.bad));
    end
  endtask

  // One transaction with out_ready already high
  task automatic run_op(input string tag, input logic [3:0] o, input logic [23:0] a, input logic [23:0] b);
    int lat;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 1);
    op = o; a_bcd = a; b_bcd = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'h0; a_bcd = 24'h123456; b_bcd = 24'h000001;
    wait_valid(lat);
    check_out(tag, lat);
    @(posedge clk); #1;
    chk({tag, "_drop"}, 64'(out_valid), 0);
    chk({tag, "_ready"}, 64'(in_ready), 1);
  endtask

  initial begin
    int          lat;
    exp_t        e;
    logic [23:0] ra, rb;
    logic [3:0]  ro;

    repeat (3) @(posedge clk);
    #1 in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_result", 64'(result_bcd), 64'h0FFFFF0);
    chk("rst_flags", 64'({neg, ovf, div0, bad}), 0);
    chk("rst_in_ready", 64'(in_ready), 1);

    run_op("add",     4'hD, 24'hFFF123, 24'hFFF877);
    run_op("sub_neg", 4'hC, 24'hFFFF15, 24'hFFFF40);
    run_op("sub_eq",  4'hC, 24'hFFFF40, 24'hFFFF40);
    run_op("mul",     4'hB, 24'hFF1000, 24'hFFF999);
    run_op("mul_ovf", 4'hB, 24'h999999, 24'hFFFF12);
    run_op("div",     4'hA, 24'hFF1000, 24'hFFFF07);
    run_op("mod",     4'h9, 24'hFF1000, 24'hFFFF07);
    run_op("div0",    4'hA, 24'hFF1000, 24'hFFFFFF);
    run_op("bad_nib", 4'hD, 24'hFFF1A3, 24'hFFFF01);
    run_op("bad_op",  4'h3, 24'hFFF123, 24'hFFF877);
    run_op("add_ovf", 4'hD, 24'h999999, 24'hFFFFF1);

    // Backpressure with in_valid left high throughout
    e = model(4'hB, 24'hFF1000, 24'hFFF999);
    sb.push_back(e);
    @(negedge clk);
    op = 4'hB; a_bcd = 24'hFF1000; b_bcd = 24'hFFF999; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    wait_valid(lat);
    check_out("bp", lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 64'(out_valid), 1);
      chk("bp_hold_res", 64'(result_bcd), 64'(e.res));
      chk("bp_hold_flags", 64'({neg, ovf, div0, bad}), 0);
      chk("bp_hold_ready", 64'(in_ready), 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop", 64'(out_valid), 0);
    chk("bp_ready", 64'(in_ready), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_no_reaccept", 64'(in_ready), 1);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = 4'hB; a_bcd = 24'hFF1000; b_bcd = 24'hFFF999; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_flags", 64'({neg, ovf, div0, bad}), 0);
    chk("mid_rst_result", 64'(result_bcd), 64'h0FFFFF0);
    chk("mid_rst_ready", 64'(in_ready), 1);
    run_op("post_rst_add", 4'hD, 24'hFFF123, 24'hFFF877);

    for (int i = 0; i < 8; i++) begin
      ro = 4'($urandom_range(9, 13));
      ra = rnd_bcd();
      rb = rnd_bcd();
      run_op("rnd", ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
